ep_bulk_in: RTL and testbench

Bulk-IN endpoint buffer sitting directly upstream of `usb_control`'s bulk data input (`blk_tvalid_i`/`blk_tlast_i`/`blk_tdata_i`). It accepts an application byte stream, buffers it in a circular RAM, and answers IN tokens with packets of up to `MAX_PACKET_SIZE` bytes. It keeps each packet until the host ACKs it, replays it on timeout or retry, manages the DATA0/DATA1 toggle, and emits zero-length packets (ZLPs) where a transfer ends on a packet boundary.

---
 rtl/usb_defs.sv | 19 +
 rtl/bram_sdp.sv | 26 ++
 rtl/ep_bulk_in.sv | 151 +++++++++++++++
 tb/tb_ep_bulk_in.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_defs.sv
// Shared USB definitions: data PID encodings, the high-speed bulk packet
// size and the bulk-IN endpoint FSM state type.
package usb_defs;

   typedef enum logic {
      DATA0 = 1'b0,
      DATA1 = 1'b1
   } data_pid_t;

   localparam int HS_BULK_MAX = 512;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT
   } ep_state_t;

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM: one write port and one read port with a registered
// read. The output holds the word addressed on the previous cycle.
module bram_sdp #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2048
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   // NOTE: the storage array has no reset; clearing it would prevent block-RAM
   // inference, and the pointers already keep unwritten words from being read.
   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: non-blocking assignments keep the registered read consistent with
   // a write that lands in the same clock edge.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/ep_bulk_in.sv
// Bulk-IN endpoint buffer: stores the application stream in a circular RAM
// and serves IN tokens with packets it holds until ACKed, including ZLPs.
module ep_bulk_in
   import usb_defs::*;
#(
   parameter int MAX_PACKET_SIZE = HS_BULK_MAX,
   parameter int BUFFER_SIZE     = 2048,
   parameter bit USE_ZLP         = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ep_reset_i,
   input  logic       blk_start_i,
   input  logic       blk_ack_i,
   input  logic       blk_timeout_i,
   output logic       ep_ready_o,
   output logic       ep_dtype_o,
   input  logic       s_tvalid_i,
   output logic       s_tready_o,
   input  logic       s_tlast_i,
   input  logic [7:0] s_tdata_i,
   output logic       m_tvalid_o,
   input  logic       m_tready_i,
   output logic       m_tlast_o,
   output logic       m_tkeep_o,
   output logic [7:0] m_tdata_o
);

   localparam int AW = $clog2(BUFFER_SIZE);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] BUF_FULL = PW'(BUFFER_SIZE);
   localparam logic [PW-1:0] MPS      = PW'(MAX_PACKET_SIZE);
   localparam logic [PW-1:0] ONE      = PW'(1);
   localparam logic [PW-1:0] TWO      = PW'(2);

   ep_state_t   state;
   logic [PW-1:0] wr_ptr, rd_base, rd_ptr, end_ptr, pkt_len, remain;
   logic          end_pend, zlp_pend, cur_zlp;

   logic [PW-1:0] level, avail, len_next, rd_next;
   logic          wr_en, beat;
   logic [7:0]    ram_q;

   assign level      = wr_ptr - rd_base;
   assign s_tready_o = (level != BUF_FULL) && !end_pend;
   assign ep_ready_o = (level >= MPS) || (end_pend && level != '0) || zlp_pend;
   assign wr_en      = s_tvalid_i && s_tready_o;
   assign beat       = (state == SEND) && m_tvalid_o && m_tready_i;
   assign avail      = end_pend ? (end_ptr - rd_base) : level;

   // Address the byte rd_ptr will hold next cycle so the RAM output always
   // matches the byte on the bus, including while stalled.
   assign rd_next    = beat ? rd_ptr + ONE : rd_ptr;
   assign m_tdata_o  = (m_tvalid_o && m_tkeep_o) ? ram_q : 8'h00;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      len_next = MPS;
      if (zlp_pend)         len_next = '0;
      else if (avail < MPS) len_next = avail;
   end

   bram_sdp #(.WIDTH(8), .DEPTH(BUFFER_SIZE)) u_ram (
      .clock (clock),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (s_tdata_i),
      .raddr (rd_next[AW-1:0]),
      .rdata (ram_q)
   );

   always_ff @(posedge clock) begin
      if (reset || ep_reset_i) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_base    <= '0;
         rd_ptr     <= '0;
         end_ptr    <= '0;
         pkt_len    <= '0;
         remain     <= '0;
         end_pend   <= 1'b0;
         zlp_pend   <= 1'b0;
         cur_zlp    <= 1'b0;
         ep_dtype_o <= DATA0;
         m_tvalid_o <= 1'b0;
         m_tlast_o  <= 1'b0;
         m_tkeep_o  <= 1'b1;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ONE;
            if (s_tlast_i) begin
               end_pend <= 1'b1;
               end_ptr  <= wr_ptr + ONE;
            end
         end

         case (state)
            IDLE: begin
               if (blk_start_i && ep_ready_o) begin
                  pkt_len <= len_next;
                  cur_zlp <= zlp_pend;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               remain     <= pkt_len;
               m_tvalid_o <= 1'b1;
               m_tlast_o  <= cur_zlp || (pkt_len == ONE);
               m_tkeep_o  <= !cur_zlp;
               state      <= SEND;
            end
            SEND: begin
               if (beat) begin
                  if (!cur_zlp) rd_ptr <= rd_ptr + ONE;
                  if (m_tlast_o) begin
                     m_tvalid_o <= 1'b0;
                     m_tlast_o  <= 1'b0;
                     m_tkeep_o  <= 1'b1;
                     state      <= WAIT;
                  end else begin
                     remain    <= remain - ONE;
                     m_tlast_o <= (remain == TWO);
                  end
               end
            end
            WAIT: begin
               if (blk_ack_i) begin
                  rd_base    <= rd_ptr;
                  ep_dtype_o <= ~ep_dtype_o;
                  if (cur_zlp) begin
                     zlp_pend <= 1'b0;
                     end_pend <= 1'b0;
                  end else if (end_pend && rd_ptr == end_ptr) begin
                     if (pkt_len == MPS && USE_ZLP) zlp_pend <= 1'b1;
                     else                           end_pend <= 1'b0;
                  end
                  state <= IDLE;
               end else if (blk_timeout_i) begin
                  rd_ptr <= rd_base;
                  state  <= IDLE;
               end else if (blk_start_i) begin
                  rd_ptr <= rd_base;
                  state  <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ep_bulk_in.sv
// Directed bench for ep_bulk_in: written bytes feed a reference queue, each
// IN pushes the expected beats and every accepted output beat is popped and compared.
module tb_ep_bulk_in;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       keep;
   } beat_t;

   logic       clock = 1'b0;
   logic       reset, ep_reset_i, blk_start_i, blk_ack_i, blk_timeout_i;
   logic       ep_ready_o, ep_dtype_o;
   logic       s_tvalid_i, s_tready_o, s_tlast_i;
   logic [7:0] s_tdata_i;
   logic       m_tvalid_o, m_tready_i, m_tlast_o, m_tkeep_o;
   logic [7:0] m_tdata_o;

   int         checks = 0;
   int         errors = 0;
   beat_t      exp_q[$];
   logic [7:0] sent_q[$];
   logic [7:0] wv = 8'h00;
   logic       exp_dtype = 1'b0;

   always #5 clock = ~clock;

   ep_bulk_in dut (
      .clock(clock), .reset(reset), .ep_reset_i(ep_reset_i),
      .blk_start_i(blk_start_i), .blk_ack_i(blk_ack_i), .blk_timeout_i(blk_timeout_i),
      .ep_ready_o(ep_ready_o), .ep_dtype_o(ep_dtype_o),
      .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i),
      .s_tdata_i(s_tdata_i),
      .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
      .m_tkeep_o(m_tkeep_o), .m_tdata_o(m_tdata_o)
   );

   initial begin
      #3ms;
      $display("FAIL watchdog: observed no finish, expected finish before 3ms");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_bytes(input int n, input bit last);
      for (int i = 0; i < n; i++) begin
         int budget = 0;
         s_tvalid_i = 1'b1;
         s_tdata_i  = wv;
         s_tlast_i  = last && (i == n - 1);
         while (!s_tready_o && budget < 200) begin
            tick();
            budget++;
         end
         if (!s_tready_o) begin
            check("write_stall", 32'(s_tready_o), 32'd1);
            break;
         end
         tick();
         sent_q.push_back(wv);
         wv = wv + 8'h01;
      end
      s_tvalid_i = 1'b0;
      s_tlast_i  = 1'b0;
   endtask

   task automatic in_token(input bit expect_send);
      check("ep_ready", 32'(ep_ready_o), 32'(expect_send));
      blk_start_i = 1'b1;
      tick();
      blk_start_i = 1'b0;
      check("valid_load", 32'(m_tvalid_o), 32'd0);
      tick();
      check("valid_2cyc", 32'(m_tvalid_o), 32'(expect_send));
      if (expect_send) check("dtype", 32'(ep_dtype_o), 32'(exp_dtype));
   endtask

   task automatic expect_pkt(input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{data: sent_q[i], last: (i == n - 1), keep: 1'b1});
   endtask

   task automatic expect_zlp();
      exp_q.push_back('{data: 8'h00, last: 1'b1, keep: 1'b0});
   endtask

   task automatic receive(input int nbeats, input bit rnd, input bit full);
      int         got = 0;
      int         budget = 0;
      bit         stalled = 1'b0;
      logic [7:0] pd = 8'h00;
      logic       pl = 1'b0;
      beat_t      e;
      while (got < nbeats && budget < 5000) begin
         m_tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled) begin
            check("hold_data", 32'(m_tdata_o), 32'(pd));
            check("hold_last", 32'(m_tlast_o), 32'(pl));
         end
         stalled = 1'b0;
         if (m_tvalid_o && m_tready_i) begin
            if (exp_q.size() == 0) begin
               check("rx_extra", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", 32'(m_tdata_o), 32'(e.data));
               check("rx_last", 32'(m_tlast_o), 32'(e.last));
               check("rx_keep", 32'(m_tkeep_o), 32'(e.keep));
            end
            got++;
         end else if (m_tvalid_o) begin
            stalled = 1'b1;
            pd = m_tdata_o;
            pl = m_tlast_o;
         end
         tick();
         budget++;
      end
      m_tready_i = 1'b1;
      if (got < nbeats) check("rx_timeout", 32'(got), 32'(nbeats));
      if (full) check("valid_after_last", 32'(m_tvalid_o), 32'd0);
   endtask

   task automatic ack_pkt(input int n, input bit with_timeout);
      blk_ack_i     = 1'b1;
      blk_timeout_i = with_timeout;
      tick();
      blk_ack_i     = 1'b0;
      blk_timeout_i = 1'b0;
      for (int i = 0; i < n; i++) void'(sent_q.pop_front());
      exp_dtype = ~exp_dtype;
   endtask

   task automatic pulse_ep_reset();
      ep_reset_i = 1'b1;
      tick();
      ep_reset_i = 1'b0;
      sent_q.delete();
      exp_q.delete();
      exp_dtype = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ep_reset_i = 1'b0; blk_start_i = 1'b0; blk_ack_i = 1'b0;
      blk_timeout_i = 1'b0; s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tdata_i = 8'h00;
      m_tready_i = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_s_tready", 32'(s_tready_o), 32'd1);
      check("rst_ep_ready", 32'(ep_ready_o), 32'd0);
      check("rst_dtype",    32'(ep_dtype_o), 32'd0);
      check("rst_m_tvalid", 32'(m_tvalid_o), 32'd0);
      check("rst_m_tlast",  32'(m_tlast_o),  32'd0);
      check("rst_m_tkeep",  32'(m_tkeep_o),  32'd1);
      check("rst_m_tdata",  32'(m_tdata_o),  32'd0);

      // Empty buffer: NAK path, nothing presented.
      in_token(1'b0);

      // 512 bytes without tlast -> one full packet on DATA0.
      write_bytes(512, 1'b0);
      in_token(1'b1);
      expect_pkt(512);
      receive(512, 1'b0, 1'b1);
      ack_pkt(512, 1'b0);
      check("t1_dtype", 32'(ep_dtype_o), 32'd1);
      check("t1_level", 32'(dut.level), 32'd0);
      check("t1_ready", 32'(ep_ready_o), 32'd0);

      // 700-byte transfer -> 512 + 188, input blocked until the final ACK.
      pulse_ep_reset();
      write_bytes(700, 1'b1);
      check("t2_blocked", 32'(s_tready_o), 32'd0);
      in_token(1'b1);
      expect_pkt(512);
      receive(512, 1'b0, 1'b1);
      ack_pkt(512, 1'b0);
      check("t2_blocked_mid", 32'(s_tready_o), 32'd0);
      in_token(1'b1);
      expect_pkt(188);
      receive(188, 1'b1, 1'b1);
      ack_pkt(188, 1'b0);
      check("t2_ready", 32'(ep_ready_o), 32'd0);
      check("t2_unblocked", 32'(s_tready_o), 32'd1);

      // 1024-byte transfer -> 512, 512, ZLP on DATA0.
      pulse_ep_reset();
      write_bytes(1024, 1'b1);
      in_token(1'b1);
      expect_pkt(512);
      receive(512, 1'b1, 1'b1);
      ack_pkt(512, 1'b0);
      in_token(1'b1);
      expect_pkt(512);
      receive(512, 1'b0, 1'b1);
      ack_pkt(512, 1'b0);
      check("t3_blocked_zlp", 32'(s_tready_o), 32'd0);
      in_token(1'b1);
      expect_zlp();
      receive(1, 1'b0, 1'b1);
      ack_pkt(0, 1'b0);
      check("t3_unblocked", 32'(s_tready_o), 32'd1);
      in_token(1'b0);

      // Timeout replay, host retry, and ACK winning over a simultaneous timeout.
      pulse_ep_reset();
      write_bytes(100, 1'b1);
      blk_ack_i = 1'b1;
      tick();
      blk_ack_i = 1'b0;
      check("t4_idle_ack_dtype", 32'(ep_dtype_o), 32'd0);
      check("t4_idle_ack_level", 32'(dut.level), 32'd100);
      in_token(1'b1);
      expect_pkt(100);
      receive(100, 1'b0, 1'b1);
      blk_timeout_i = 1'b1;
      tick();
      blk_timeout_i = 1'b0;
      check("t4_level", 32'(dut.level), 32'd100);
      in_token(1'b1);
      expect_pkt(100);
      receive(100, 1'b1, 1'b1);
      in_token(1'b1);
      expect_pkt(100);
      receive(100, 1'b0, 1'b1);
      ack_pkt(100, 1'b1);
      check("t4_dtype", 32'(ep_dtype_o), 32'd1);
      check("t4_ready", 32'(ep_ready_o), 32'd0);
      check("t4_unblocked", 32'(s_tready_o), 32'd1);

      // Endpoint reset in the middle of a packet.
      pulse_ep_reset();
      write_bytes(512, 1'b0);
      ack_pkt(0, 1'b0);
      exp_dtype = 1'b0;
      in_token(1'b1);
      expect_pkt(512);
      receive(36, 1'b0, 1'b0);
      check("t5_mid_valid", 32'(m_tvalid_o), 32'd1);
      ep_reset_i = 1'b1;
      tick();
      ep_reset_i = 1'b0;
      check("t5_valid", 32'(m_tvalid_o), 32'd0);
      check("t5_last",  32'(m_tlast_o),  32'd0);
      check("t5_level", 32'(dut.level),  32'd0);
      check("t5_dtype", 32'(ep_dtype_o), 32'd0);
      sent_q.delete();
      exp_q.delete();
      exp_dtype = 1'b0;

      // Fill the whole buffer.
      write_bytes(2048, 1'b0);
      check("t6_full", 32'(s_tready_o), 32'd0);
      check("t6_level", 32'(dut.level), 32'd2048);

      // Many transfers carrying the pointers across the RAM and pointer wrap.
      pulse_ep_reset();
      for (int p = 0; p < 15; p++) begin
         write_bytes(300, 1'b1);
         in_token(1'b1);
         expect_pkt(300);
         receive(300, p[0], 1'b1);
         ack_pkt(300, 1'b0);
      end
      check("t7_ready", 32'(ep_ready_o), 32'd0);
      check("t7_level", 32'(dut.level), 32'd0);
      check("t7_leftover", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
